// File: rtl/bist_pkg.sv
// Shared types and polynomial tables for the parameterised BIST adder.
// lfsr_poly() and misr_poly() return the tap set for a given adder WIDTH.
package bist_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Left-shift Galois taps; the x^n term is implicit in the shifted-out msb.
   localparam logic [63:0] LFSR_POLY_16 = 64'h0000_0000_0000_6801;
   localparam logic [63:0] LFSR_POLY_32 = 64'h0000_0000_0040_0007;
   localparam logic [63:0] LFSR_POLY_64 = 64'hB000_0000_0000_0001;

   localparam logic [32:0] MISR_POLY_9  = 33'h0_0000_0011;
   localparam logic [32:0] MISR_POLY_17 = 33'h0_0000_0009;
   localparam logic [32:0] MISR_POLY_33 = 33'h0_0000_2001;

   function automatic logic [63:0] lfsr_poly(input int width);
      case (width)
         8:       return LFSR_POLY_16;
         16:      return LFSR_POLY_32;
         32:      return LFSR_POLY_64;
         default: return 64'h0;
      endcase
   endfunction

   function automatic logic [32:0] misr_poly(input int width);
      case (width)
         8:       return MISR_POLY_9;
         16:      return MISR_POLY_17;
         32:      return MISR_POLY_33;
         default: return 33'h0;
      endcase
   endfunction

endpackage

// File: rtl/bist_lfsr.sv
// Left-shift Galois LFSR with synchronous load and step enable.
module bist_lfsr #(
   parameter int             LEN  = 32,
   parameter logic [LEN-1:0] POLY = {{(LEN-1){1'b0}}, 1'b1}
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           load,
   input  logic [LEN-1:0] seed,
   input  logic           en,
   output logic [LEN-1:0] q
);

   logic [LEN-1:0] q_next;

   assign q_next = {q[LEN-2:0], 1'b0} ^ (q[LEN-1] ? POLY : '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= seed;
      end else if (en) begin
         q <= q_next;
      end
   end

endmodule

// File: rtl/bist_adder_param.sv
// Self-testing adder: LFSR operands, a+b compacted into a MISR over PATTERNS vectors.
// Optional golden compare on the pass output is enabled by defining BIST_GOLDEN_CHECK_EN.
module bist_adder_param
   import bist_pkg::*;
#(
   parameter int                  WIDTH    = 16,
   parameter int                  PATTERNS = 128,
   parameter logic [2*WIDTH-1:0]  SEED     = {{(2*WIDTH-1){1'b0}}, 1'b1}
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [WIDTH:0] golden,
   output logic           busy,
   output logic           finish,
   output logic [WIDTH:0] signature,
   output logic           pass
);

   localparam int              LEN      = 2 * WIDTH;
   localparam logic [63:0]     LFSR_TAB = lfsr_poly(WIDTH);
   localparam logic [LEN-1:0]  LFSR_P   = LFSR_TAB[LEN-1:0];
   localparam logic [32:0]     MISR_TAB = misr_poly(WIDTH);
   localparam logic [WIDTH:0]  MISR_P   = MISR_TAB[WIDTH:0];
   // An all-zero LFSR never leaves zero, so a zero seed is replaced by 1.
   localparam logic [LEN-1:0]  SEED_EFF = (SEED == '0) ? {{(LEN-1){1'b0}}, 1'b1} : SEED;
   localparam logic [15:0]     LAST     = 16'(PATTERNS - 1);

   if (!(WIDTH == 8 || WIDTH == 16 || WIDTH == 32)) begin : g_width_check
      $fatal(1, "bist_adder_param: WIDTH must be 8, 16 or 32");
   end

   if (PATTERNS < 1 || PATTERNS > 65535) begin : g_patterns_check
      $fatal(1, "bist_adder_param: PATTERNS must be within 1..65535");
   end

   state_t          state;
   state_t          state_next;
   logic            load;
   logic            step;
   logic            last;
   logic [LEN-1:0]  lfsr;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH:0]  sum;
   logic [WIDTH:0]  misr;
   logic [WIDTH:0]  misr_next;
   logic [15:0]     cnt;

   bist_lfsr #(
      .LEN  (LEN),
      .POLY (LFSR_P)
   ) u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .seed  (SEED_EFF),
      .en    (step),
      .q     (lfsr)
   );

   assign a         = lfsr[LEN-1:WIDTH];
   assign b         = lfsr[WIDTH-1:0];
   assign sum       = {1'b0, a} + {1'b0, b};
   assign misr_next = {misr[WIDTH-1:0], 1'b0} ^ (misr[WIDTH] ? MISR_P : '0) ^ sum;
   assign last      = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Start is only honoured outside RUN; a start during RUN is dropped.
   always_comb begin
      state_next = state;
      load       = 1'b0;
      step       = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         RUN: begin
            step = 1'b1;
            if (last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (start) begin
               state_next = RUN;
               load       = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misr <= '0;
         cnt  <= '0;
      end else if (load) begin
         misr <= '0;
         cnt  <= '0;
      end else if (step) begin
         misr <= misr_next;
         cnt  <= cnt + 16'd1;
      end
   end

   assign busy      = (state == RUN);
   assign finish    = (state == DONE);
   assign signature = misr;

`ifdef BIST_GOLDEN_CHECK_EN
   logic pass_q;

   // Compare against the final MISR value being written on the RUN-to-DONE edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pass_q <= 1'b0;
      end else if (load) begin
         pass_q <= 1'b0;
      end else if (step && last) begin
         pass_q <= (misr_next == golden);
      end
   end

   assign pass = pass_q;
`else
   logic unused_golden;

   assign unused_golden = ^golden;
   assign pass          = 1'b0;
`endif

endmodule

// File: tb/tb_bist_adder_param.sv
// Scoreboard bench for bist_adder_param: randomized runs against a plain-arithmetic signature model.
module tb_bist_adder_param;

`ifdef BIST_GOLDEN_CHECK_EN
   localparam bit GOLD_EN = 1'b1;
`else
   localparam bit GOLD_EN = 1'b0;
`endif

   typedef struct {
      logic [16:0] sig;
      logic        pass;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        start_k;
   logic [16:0] golden;

   logic        busy, finish, pass;
   logic [16:0] signature;
   logic        busy_z, finish_z, pass_z;
   logic [16:0] sig_z;
   logic        busy_a, finish_a, pass_a;
   logic [16:0] sig_a;
   logic        busy_c, finish_c, pass_c;
   logic [16:0] sig_c;

   int          checks = 0;
   int          errors = 0;
   exp_t        q_main[$];
   exp_t        q_z[$];
   logic [16:0] ref_main;

   always #5 clk = ~clk;

   bist_adder_param dut (
      .clk (clk), .rst_n (rst_n), .start (start), .golden (golden),
      .busy (busy), .finish (finish), .signature (signature), .pass (pass)
   );

   bist_adder_param #(.WIDTH(16), .PATTERNS(128), .SEED(32'h0000_0000)) dut_z (
      .clk (clk), .rst_n (rst_n), .start (start), .golden (golden),
      .busy (busy_z), .finish (finish_z), .signature (sig_z), .pass (pass_z)
   );

   bist_adder_param #(.WIDTH(16), .PATTERNS(1), .SEED(32'h0001_0002)) dut_a (
      .clk (clk), .rst_n (rst_n), .start (start_k), .golden (17'h00003),
      .busy (busy_a), .finish (finish_a), .signature (sig_a), .pass (pass_a)
   );

   bist_adder_param #(.WIDTH(16), .PATTERNS(1), .SEED(32'hFFFF_0001)) dut_c (
      .clk (clk), .rst_n (rst_n), .start (start_k), .golden (17'h10001),
      .busy (busy_c), .finish (finish_c), .signature (sig_c), .pass (pass_c)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Signature computed straight from the arithmetic rules: operands are the two
   // halves of the LFSR word, their sum is folded into a 17-bit MISR.
   function automatic logic [16:0] ref_sig(input logic [31:0] seed, input int n);
      logic [31:0] l;
      logic [16:0] m;
      logic        fb;
      int unsigned s;
      l = (seed == 32'h0) ? 32'd1 : seed;
      m = 17'h0;
      for (int i = 0; i < n; i++) begin
         s  = int'(l >> 16) + int'(l & 32'h0000_FFFF);
         fb = m[16];
         m  = 17'(m << 1) ^ (fb ? 17'h00009 : 17'h0) ^ 17'(s);
         l  = (l << 1) ^ (l[31] ? 32'h0040_0007 : 32'h0);
      end
      return m;
   endfunction

   logic        fin_d_m = 1'b0;
   int          busy_n_m = 0;
   logic [16:0] held_m = '0;
   exp_t        e_m;

   always @(negedge clk) begin
      if (!rst_n) begin
         fin_d_m  = 1'b0;
         busy_n_m = 0;
      end else begin
         if (busy) busy_n_m++;
         if (finish && !fin_d_m) begin
            if (q_main.size() == 0) begin
               chk("main_unexpected_finish", 64'd1, 64'd0);
            end else begin
               e_m = q_main.pop_front();
               chk("main_signature", signature, e_m.sig);
               chk("main_pass", pass, e_m.pass);
               chk("main_busy_cycles", busy_n_m, 128);
            end
            busy_n_m = 0;
            held_m   = signature;
         end else if (finish) begin
            chk("main_signature_hold", signature, held_m);
         end
         fin_d_m = finish;
      end
   end

   logic        fin_d_z = 1'b0;
   int          busy_n_z = 0;
   exp_t        e_z;

   always @(negedge clk) begin
      if (!rst_n) begin
         fin_d_z  = 1'b0;
         busy_n_z = 0;
      end else begin
         if (busy_z) busy_n_z++;
         if (finish_z && !fin_d_z) begin
            if (q_z.size() == 0) begin
               chk("seed0_unexpected_finish", 64'd1, 64'd0);
            end else begin
               e_z = q_z.pop_front();
               chk("seed0_signature", sig_z, e_z.sig);
               chk("seed0_pass", pass_z, e_z.pass);
               chk("seed0_busy_cycles", busy_n_z, 128);
            end
            busy_n_z = 0;
         end
         fin_d_z = finish_z;
      end
   end

   task automatic run(input logic [16:0] g, input bit stress);
      exp_t e;
      bit   done;
      golden = g;
      e.sig  = ref_main;
      e.pass = GOLD_EN && (g == ref_main);
      q_main.push_back(e);
      q_z.push_back(e);
      start = 1'b1;
      @(negedge clk);
      done = 1'b0;
      for (int n = 0; n < 400 && !done; n++) begin
         if (finish) begin
            start = 1'b0;
            done  = 1'b1;
         end else begin
            start = stress ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
         end
      end
      start = 1'b0;
      if (!done) chk("run_timeout", 64'd0, 64'd1);
      repeat ($urandom_range(2, 5)) @(negedge clk);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_finish"}, finish, 0);
      chk({tag, "_signature"}, signature, 0);
      chk({tag, "_pass"}, pass, 0);
      chk({tag, "_seed0_outputs"}, {busy_z, finish_z, pass_z, sig_z}, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      start    = 1'b0;
      start_k  = 1'b0;
      golden   = '0;
      ref_main = ref_sig(32'h0000_0001, 128);
      repeat (3) @(negedge clk);
      chk_all_zero("reset");
      chk("reset_kat_outputs", {busy_a, finish_a, pass_a, sig_a, busy_c, finish_c, pass_c, sig_c}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Single-pattern known answers, including the carry-out case.
      start_k = 1'b1;
      @(negedge clk);
      start_k = 1'b0;
      chk("kat_busy_first", busy_a, 1);
      chk("kat_finish_early", finish_a, 0);
      @(negedge clk);
      chk("kat_finish", finish_a, 1);
      chk("kat_busy_after", busy_a, 0);
      chk("kat_signature", sig_a, 17'h00003);
      chk("kat_pass", pass_a, GOLD_EN);
      chk("carry_signature", sig_c, 17'h10000);
      chk("carry_pass", pass_c, 0);
      repeat (3) @(negedge clk);
      chk("kat_signature_hold", sig_a, 17'h00003);

      run(ref_main, 1'b0);
      run(ref_main ^ 17'h00001, 1'b0);
      run(ref_main, 1'b1);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(0, 4)) @(negedge clk);
         if ($urandom_range(0, 1) == 1)
            run(ref_main, 1'($urandom_range(0, 1)));
         else
            run(ref_main ^ 17'($urandom_range(1, 17'h1FFFF)), 1'($urandom_range(0, 1)));
      end

      // Abort mid-run: everything clears at once and no finish follows.
      golden = ref_main;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (49) @(negedge clk);
      chk("abort_busy_before", busy, 1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("abort");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("abort_stays_idle", {busy, finish, busy_z, finish_z}, 0);
      run(ref_main, 1'b0);

      repeat (3) @(negedge clk);
      chk("main_queue_drained", q_main.size(), 0);
      chk("seed0_queue_drained", q_z.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
